// File: rtl/gb_fb_arbiter.sv
// gb_fb_arbiter: single-port frame buffer arbiter and sequencer.
// VGA reads take the RAM port first; PPU writes queue and drain into idle cycles.
module gb_fb_arbiter #(
    parameter int                ADDR_W       = 15,
    parameter int                DATA_W       = 2,
    parameter int                FB_SIZE      = 23040,
    parameter int                FIFO_DEPTH   = 4,
    parameter int                STARVE_LIMIT = 1024,
    parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    input  logic                          clr_req,
    input  logic                          ppu_wr_req,
    input  logic [ADDR_W-1:0]             ppu_wr_addr,
    input  logic [DATA_W-1:0]             ppu_wr_data,
    output logic                          ppu_wr_ready,
    input  logic                          vga_rd_req,
    input  logic [ADDR_W-1:0]             vga_rd_addr,
    output logic                          vga_rd_valid,
    output logic [DATA_W-1:0]             vga_rd_data,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic                          ram_we,
    output logic [DATA_W-1:0]             ram_wdata,
    input  logic [DATA_W-1:0]             ram_rdata,
    output logic                          clear_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          starve_flag
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(FB_SIZE - 1);
    localparam logic [PW:0]       FULL  = (PW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]     LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr, ptr_nx;
    logic              we_nx, last_nx, last_q;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] wdata_nx;

    logic [ADDR_W-1:0] f_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] f_data [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic              push, pop;

    logic              p1_v, p1_fake, p2_v, p2_fake;
    logic [CW-1:0]     starve_cnt;

    assign ppu_wr_ready = (state == S_RUN) && clear_done && (fifo_level != FULL);
    assign push = ppu_wr_req && ppu_wr_ready && !clr_req;
    assign pop  = (state == S_RUN) && !vga_rd_req && (fifo_level != '0) && !clr_req;

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        we_nx    = 1'b0;
        addr_nx  = ram_addr;
        wdata_nx = ram_wdata;
        last_nx  = 1'b0;
        unique case (state)
            S_CLEAR: begin
                we_nx    = 1'b1;
                addr_nx  = ptr;
                wdata_nx = CLEAR_VALUE;
                ptr_nx   = ptr + 1'b1;
                if (ptr == LAST) begin
                    state_nx = S_RUN;
                    last_nx  = 1'b1;
                end
            end
            S_RUN: begin
                if (vga_rd_req) begin
                    addr_nx = vga_rd_addr;
                end else if (pop) begin
                    we_nx    = 1'b1;
                    addr_nx  = f_addr[rd_ptr];
                    wdata_nx = f_data[rd_ptr];
                end
            end
            default: ;
        endcase
        // A clear request restarts the sweep; a read issued this cycle still goes out.
        if (clr_req) begin
            state_nx = S_CLEAR;
            ptr_nx   = '0;
            last_nx  = 1'b0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state        <= S_CLEAR;
            ptr          <= '0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            last_q       <= 1'b0;
            clear_done   <= 1'b0;
            p1_v         <= 1'b0;
            p1_fake      <= 1'b0;
            p2_v         <= 1'b0;
            p2_fake      <= 1'b0;
            vga_rd_valid <= 1'b0;
            vga_rd_data  <= '0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            ram_we    <= we_nx;
            ram_addr  <= addr_nx;
            ram_wdata <= wdata_nx;
            last_q    <= last_nx;
            if (clr_req) begin
                clear_done <= 1'b0;
            end else if (last_q) begin
                clear_done <= 1'b1;
            end
            // Reads during a clear never reach RAM and return the clear value.
            p1_v         <= vga_rd_req;
            p1_fake      <= (state == S_CLEAR);
            p2_v         <= p1_v;
            p2_fake      <= p1_fake;
            vga_rd_valid <= p2_v;
            vga_rd_data  <= p2_fake ? CLEAR_VALUE : ram_rdata;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset || clr_req) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (push) begin
            f_addr[wr_ptr] <= ppu_wr_addr;
            f_data[wr_ptr] <= ppu_wr_data;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset || clr_req) begin
            starve_cnt  <= '0;
            starve_flag <= 1'b0;
        end else if (pop) begin
            starve_cnt <= '0;
        end else if ((state == S_RUN) && (fifo_level != '0) && vga_rd_req
                     && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
            if (starve_cnt + 1'b1 == LIMIT) begin
                starve_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gb_fb_arbiter.sv
// Bench for gb_fb_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_gb_fb_arbiter;

    localparam int AW    = 15;
    localparam int DW    = 2;
    localparam int FBS   = 23040;
    localparam int DEPTH = 4;
    localparam int LIMIT = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr, wreq, rreq;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] wdata;
    logic          ppu_wr_ready, vga_rd_valid, ram_we, clear_done, starve_flag;
    logic [DW-1:0] vga_rd_data, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;
    logic [2:0]    fifo_level;

    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    logic [DW-1:0] mem  [0:32767];
    logic [DW-1:0] gold [0:32767];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gb_fb_arbiter dut (
        .clk_clk(clk), .reset_reset(rst), .clr_req(clr),
        .ppu_wr_req(wreq), .ppu_wr_addr(waddr), .ppu_wr_data(wdata),
        .ppu_wr_ready(ppu_wr_ready),
        .vga_rd_req(rreq), .vga_rd_addr(raddr),
        .vga_rd_valid(vga_rd_valid), .vga_rd_data(vga_rd_data),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .clear_done(clear_done),
        .fifo_level(fifo_level), .starve_flag(starve_flag)
    );

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: pending writes in a queue, reads in a 3-cycle delay line.
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    typedef struct { bit v; logic [DW-1:0] d; } rd_t;

    wr_t           q[$];
    rd_t           line0, line1;
    bit            m_clearing, m_done, m_last, m_flag, armed = 1'b0;
    int            m_ptr, m_cnt;
    bit            e_we, e_valid;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_data;

    function automatic bit m_ready();
        return !m_clearing && m_done && (q.size() < DEPTH);
    endfunction

    always @(posedge clk) begin : model
        bit  push, pop, run, busy;
        wr_t h;
        rd_t nr;
        if (rst) begin
            q.delete();
            m_clearing = 1'b1; m_ptr = 0; m_done = 1'b0; m_last = 1'b0;
            m_flag = 1'b0; m_cnt = 0;
            line0 = '{1'b0, 2'b00}; line1 = '{1'b0, 2'b00};
            e_we = 1'b0; e_addr = '0; e_wdata = '0;
            e_valid = 1'b0; e_data = '0;
            armed = 1'b1;
        end else begin
            run  = !m_clearing;
            busy = q.size() > 0;
            push = wreq && m_ready() && !clr;
            pop  = run && !rreq && busy && !clr;
            e_valid = line1.v; e_data = line1.d;
            line1 = line0;
            nr.v = rreq;
            nr.d = m_clearing ? 2'b00 : gold[raddr];
            line0 = nr;
            if (pl_en) gold[pl_addr] = pl_data;
            if (clr) m_done = 1'b0;
            else if (m_last) m_done = 1'b1;
            m_last = 1'b0;
            if (m_clearing) begin
                e_we = 1'b1; e_addr = AW'(m_ptr); e_wdata = 2'b00;
                gold[m_ptr] = 2'b00;
                if (m_ptr == FBS - 1) begin
                    m_clearing = 1'b0; m_last = 1'b1;
                end
                m_ptr++;
            end else if (rreq) begin
                e_we = 1'b0; e_addr = raddr;
            end else if (pop) begin
                h = q.pop_front();
                e_we = 1'b1; e_addr = h.a; e_wdata = h.d;
                gold[h.a] = h.d;
            end else begin
                e_we = 1'b0;
            end
            if (clr) begin
                m_cnt = 0; m_flag = 1'b0;
            end else if (pop) begin
                m_cnt = 0;
            end else if (run && busy && rreq && m_cnt < LIMIT) begin
                m_cnt++;
                if (m_cnt == LIMIT) m_flag = 1'b1;
            end
            if (push) q.push_back('{waddr, wdata});
            if (clr) begin
                q.delete(); m_clearing = 1'b1; m_ptr = 0; m_last = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("m_ram_we", 32'(ram_we), 32'(e_we));
            chk("m_ram_addr", 32'(ram_addr), 32'(e_addr));
            if (e_we) chk("m_ram_wdata", 32'(ram_wdata), 32'(e_wdata));
            chk("m_rd_valid", 32'(vga_rd_valid), 32'(e_valid));
            if (e_valid) chk("m_rd_data", 32'(vga_rd_data), 32'(e_data));
            chk("m_ready", 32'(ppu_wr_ready), 32'(m_ready()));
            chk("m_level", 32'(fifo_level), q.size());
            chk("m_done", 32'(clear_done), 32'(m_done));
            chk("m_starve", 32'(starve_flag), 32'(m_flag));
        end
    end

    logic [DW-1:0] wd [4] = '{2'd1, 2'd2, 2'd3, 2'd1};

    initial begin
        int nwe, lastwe, donecyc, nv, first, lastv, bad;
        bit seq_ok, dat_ok, we_seen;
        clr = 0; wreq = 0; rreq = 0; waddr = '0; raddr = '0; wdata = '0;
        pl_en = 0; pl_addr = '0; pl_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(ram_we), 0);
        chk("rst_done", 32'(clear_done), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_valid", 32'(vga_rd_valid), 0);
        chk("rst_ready", 32'(ppu_wr_ready), 0);
        rst = 0;

        // Power-up clear sweep
        nwe = 0; lastwe = -1; donecyc = -1; seq_ok = 1;
        for (int k = 1; k <= FBS + 10 && donecyc < 0; k++) begin
            @(negedge clk);
            if (ram_we) begin
                if (ram_addr != AW'(nwe) || ram_wdata != 2'b00) seq_ok = 0;
                nwe++; lastwe = k;
            end
            if (!clear_done && ppu_wr_ready) seq_ok = 0;
            if (clear_done) donecyc = k;
        end
        chk("clr_we_count", nwe, 23040);
        chk("clr_last_cycle", lastwe, 23040);
        chk("clr_done_cycle", donecyc, 23041);
        chk("clr_seq", 32'(seq_ok), 1);

        // Single read of a preloaded pixel
        pl_en = 1; pl_addr = 15'h1234; pl_data = 2'd3;
        @(negedge clk);
        pl_en = 0; rreq = 1; raddr = 15'h1234;
        @(negedge clk);
        rreq = 0;
        chk("rd_port_addr", 32'(ram_addr), 32'h1234);
        chk("rd_port_we", 32'(ram_we), 0);
        chk("rd_n1_valid", 32'(vga_rd_valid), 0);
        @(negedge clk);
        chk("rd_n2_valid", 32'(vga_rd_valid), 0);
        @(negedge clk);
        chk("rd_n3_valid", 32'(vga_rd_valid), 1);
        chk("rd_n3_data", 32'(vga_rd_data), 3);
        @(negedge clk);
        chk("rd_n4_valid", 32'(vga_rd_valid), 0);

        // Eight back-to-back reads
        for (int i = 0; i < 8; i++) begin
            pl_en = 1; pl_addr = AW'(32'h100 + i); pl_data = DW'(i);
            @(negedge clk);
        end
        pl_en = 0;
        nv = 0; first = -1; lastv = -1; dat_ok = 1;
        for (int i = 0; i < 20; i++) begin
            if (i < 8) begin rreq = 1; raddr = AW'(32'h100 + i); end
            else rreq = 0;
            @(negedge clk);
            if (vga_rd_valid) begin
                if (first < 0) first = i;
                if (vga_rd_data != DW'(nv)) dat_ok = 0;
                nv++; lastv = i;
            end
        end
        chk("burst_count", nv, 8);
        chk("burst_first", first, 2);
        chk("burst_span", lastv - first, 7);
        chk("burst_data", 32'(dat_ok), 1);

        // Four writes blocked behind reads, then drained in order
        rreq = 1; raddr = 15'h10; we_seen = 0;
        for (int i = 0; i < 4; i++) begin
            wreq = 1; waddr = AW'(32'h200 + i); wdata = wd[i];
            @(negedge clk);
            if (ram_we) we_seen = 1;
        end
        wreq = 0;
        @(negedge clk);
        if (ram_we) we_seen = 1;
        chk("blk_level", 32'(fifo_level), 4);
        chk("blk_ready", 32'(ppu_wr_ready), 0);
        chk("blk_no_we", 32'(we_seen), 0);
        rreq = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_we", 32'(ram_we), 1);
            chk("drain_addr", 32'(ram_addr), 32'h200 + i);
            chk("drain_data", 32'(ram_wdata), 32'(wd[i]));
            if (i == 0) chk("drain_ready", 32'(ppu_wr_ready), 1);
        end
        @(negedge clk);
        chk("drain_idle", 32'(ram_we), 0);

        // Push attempted against a full FIFO while a pop happens
        rreq = 1;
        for (int i = 0; i < 4; i++) begin
            wreq = 1; waddr = AW'(32'h300 + i); wdata = 2'd2;
            @(negedge clk);
        end
        wreq = 0;
        @(negedge clk);
        chk("full_level", 32'(fifo_level), 4);
        rreq = 0; wreq = 1; waddr = 15'h3FF; wdata = 2'd2;
        @(negedge clk);
        wreq = 0;
        chk("full_pop_level", 32'(fifo_level), 3);
        chk("full_pop_addr", 32'(ram_addr), 32'h300);
        repeat (5) @(negedge clk);
        chk("full_empty", 32'(fifo_level), 0);
        chk("full_rejected", 32'(mem[15'h3FF]), 0);

        // Starvation, then clear with writes pending and a read in flight
        rreq = 1; raddr = 15'h20;
        for (int i = 0; i < 4; i++) begin
            wreq = 1; waddr = AW'(32'h500 + i); wdata = 2'd3;
            @(negedge clk);
        end
        wreq = 0;
        repeat (LIMIT - 10) @(negedge clk);
        chk("starve_early", 32'(starve_flag), 0);
        repeat (20) @(negedge clk);
        chk("starve_set", 32'(starve_flag), 1);
        rreq = 0;
        @(negedge clk);
        chk("starve_sticky", 32'(starve_flag), 1);
        chk("starve_pop_addr", 32'(ram_addr), 32'h500);
        chk("pending_level", 32'(fifo_level), 3);
        rreq = 1; raddr = 15'h1234;
        @(negedge clk);
        rreq = 0; clr = 1;
        @(negedge clk);
        clr = 0;
        chk("cl_starve", 32'(starve_flag), 0);
        chk("cl_done", 32'(clear_done), 0);
        chk("cl_level", 32'(fifo_level), 0);
        chk("cl_ready", 32'(ppu_wr_ready), 0);
        @(negedge clk);
        chk("cl_inflight_valid", 32'(vga_rd_valid), 1);
        chk("cl_inflight_data", 32'(vga_rd_data), 3);
        chk("cl_restart_we", 32'(ram_we), 1);
        chk("cl_restart_addr", 32'(ram_addr), 0);
        bad = 0; donecyc = -1;
        for (int k = 1; k <= FBS + 10 && donecyc < 0; k++) begin
            @(negedge clk);
            if (k < 3 && ram_addr != AW'(k)) bad++;
            if (ram_we && ram_wdata != 2'b00) bad++;
            if (clear_done) donecyc = k;
        end
        chk("cl_no_pending", bad, 0);
        chk("cl_done_cycle", donecyc, 23040);
        chk("cl_mem_501", 32'(mem[15'h501]), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gb_fb_arbiter.md
Name: gb_fb_arbiter

Overview:
- Single-port arbiter and sequencer for the on-chip Game Boy frame buffer RAM, which holds 160x144 pixels at 2 bits per pixel.
- Sits between the PPU pixel writer and the VGA scan-out reader.
- VGA reads get absolute priority and a fixed latency. PPU writes are absorbed in a small FIFO and drained into idle RAM cycles.
- Clears the whole buffer after reset or on request.

Parameters:
- ADDR_W, 15, frame buffer address width
- DATA_W, 2, pixel width
- FB_SIZE, 23040, number of pixel locations
- FIFO_DEPTH, 4, write FIFO entries; must be a power of 2, at least 2
- STARVE_LIMIT, 1024, consecutive blocked-drain cycles before starve_flag sets
- CLEAR_VALUE, 0, pixel value written during clear

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  synchronous, active-high reset
- clr_req  in  1  one-cycle pulse: flush the FIFO and clear the buffer
- ppu_wr_req  in  1  PPU write request
- ppu_wr_addr  in  ADDR_W  write address
- ppu_wr_data  in  DATA_W  write pixel
- ppu_wr_ready  out  1  FIFO can accept a write
- vga_rd_req  in  1  VGA read request; no back-pressure
- vga_rd_addr  in  ADDR_W  read address
- vga_rd_valid  out  1  read data valid
- vga_rd_data  out  DATA_W  read pixel
- ram_addr  out  ADDR_W  RAM address (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_wdata  out  DATA_W  RAM write data (registered)
- ram_rdata  in  DATA_W  RAM read data, one cycle after ram_addr
- clear_done  out  1  high once a clear has finished; low while CLEAR runs
- fifo_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
- starve_flag  out  1  sticky starvation indicator; cleared by reset or clr_req

Behaviour:
- Reset values: all outputs 0, FSM = CLEAR, clear pointer = 0, FIFO empty, starve counter = 0.
- Reset asserted mid-operation aborts everything; the clear restarts from address 0.
- FSM states: CLEAR and RUN.
- CLEAR state:
  - Each cycle: ram_we=1, ram_addr=ptr, ram_wdata=CLEAR_VALUE, then ptr++.
  - After writing address FB_SIZE-1, next state is RUN and clear_done goes to 1.
  - ppu_wr_ready = 0.
  - VGA reads do not touch RAM, but still return vga_rd_valid at the normal latency with data CLEAR_VALUE.
- RUN state:
  - ppu_wr_ready = !(registered fifo_level == FIFO_DEPTH). A pop in the same cycle does not open a slot.
  - A write is accepted (pushed) when ppu_wr_req && ppu_wr_ready.
  - Read path: vga_rd_req sampled in cycle N gives ram_addr=vga_rd_addr, ram_we=0 in N+1. ram_rdata is captured in N+2. vga_rd_valid=1 with vga_rd_data in N+3. The pipeline is fully throughputted: one read per cycle, sustained.
  - Drain: in any cycle with vga_rd_req low and the FIFO non-empty, pop the head; next cycle ram_we=1 with its addr/data.
  - Simultaneous push and pop: both happen; fifo_level is unchanged.
  - No read-after-write forwarding: reads return RAM contents, so pending FIFO writes are not visible.
  - Idle cycle (no read, FIFO empty): ram_we=0, and ram_addr holds its last value.
- Starvation:
  - The counter increments each RUN cycle where the FIFO is non-empty and vga_rd_req=1. It resets to 0 on any pop.
  - When it reaches STARVE_LIMIT, starve_flag is set and stays set. The counter saturates.
- clr_req:
  - In RUN or CLEAR: FIFO flushed (pending writes discarded), ptr=0, clear_done=0, starve_flag=0, next state CLEAR.
  - clr_req during CLEAR restarts the clear at 0.
  - A write presented in the same cycle as clr_req is dropped.
  - Reads already in flight complete with their real RAM data.
- Addresses >= FB_SIZE are passed through unchanged and are not checked.

Test Plan:
- Reset then run FB_SIZE+2 cycles:
  - ram_we=1 on exactly 23040 consecutive cycles over addresses 0..23039 with data 0.
  - clear_done rises the cycle after address 23039 is written.
  - ppu_wr_ready is 0 throughout.
- After clear, with RAM preloaded so addr 0x1234 = 3, pulse vga_rd_req in cycle N -> vga_rd_valid=1, vga_rd_data=3 in N+3 only. A back-to-back 8-read burst returns 8 consecutive valids.
- Four PPU writes with vga_rd_req held high -> fifo_level=4, ppu_wr_ready=0, no ram_we. Drop vga_rd_req -> the 4 writes appear on consecutive cycles in FIFO order, and ready reasserts after the first pop.
- FIFO full and a push attempted while a pop occurs in the same cycle -> push rejected, fifo_level goes from 4 to 3.
- Hold vga_rd_req high for 1024 cycles with the FIFO non-empty -> starve_flag=1 and stays set after reads stop. A clr_req clears it.
- clr_req with 3 writes pending and a read in flight -> the pending writes never reach RAM. The in-flight read still returns valid at N+3. The clear restarts at address 0.
